// File: rtl/dma_request_gen_if.sv
// Request/acknowledge bundle between request sources, the conditioner and the bus arbiter.
// The master side drives sources, controls and DACK; the slave side is the conditioner.
interface dma_request_gen_if #(
  parameter int CHANNELS = 4,
  parameter int PEND_W   = 2
);
  logic [CHANNELS-1:0]        source;
  logic [CHANNELS-1:0]        mode_edge;
  logic [CHANNELS-1:0]        channel_enable;
  logic [CHANNELS-1:0]        dma_acknowledge_n;
  logic [CHANNELS-1:0]        overflow_clear;
  logic [CHANNELS-1:0]        dma_request;
  logic [CHANNELS*PEND_W-1:0] pending_count;
  logic [CHANNELS-1:0]        overflow;

  modport master (
    output source, mode_edge, channel_enable, dma_acknowledge_n, overflow_clear,
    input  dma_request, pending_count, overflow
  );

  modport slave (
    input  source, mode_edge, channel_enable, dma_acknowledge_n, overflow_clear,
    output dma_request, pending_count, overflow
  );
endinterface

// File: rtl/dma_request_gen.sv
// Per-channel DMA request conditioner: rising edges are counted into a saturating
// pending counter (edge mode) or the source is passed straight through (level mode).
module dma_request_gen #(
  parameter int CHANNELS    = 4,
  parameter int PEND_W      = 2,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clock,
  input  logic             reset,
  dma_request_gen_if.slave bus
);

  localparam logic [PEND_W-1:0] MaxPend = '1;

  logic [CHANNELS-1:0] w_srcS;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_ackStart;
  logic [CHANNELS-1:0] w_modeChange;
  logic [CHANNELS-1:0] w_ack;
  logic [CHANNELS-1:0] w_ovfSet;
  logic [CHANNELS-1:0] w_requestNext;
  logic [CHANNELS-1:0] w_overflowNext;
  logic [PEND_W-1:0]   w_pendingNext [CHANNELS];
  logic [CHANNELS*PEND_W-1:0] w_pendFlat;

  logic [CHANNELS-1:0] r_prevSrc;
  logic [CHANNELS-1:0] r_prevDack;
  logic [CHANNELS-1:0] r_prevMode;
  logic [CHANNELS-1:0] r_request;
  logic [CHANNELS-1:0] r_overflow;
  logic [PEND_W-1:0]   r_pending [CHANNELS];

  generate
    if (SYNC_STAGES == 0) begin : g_noSync
      assign w_srcS = bus.source;
    end else begin : g_sync
      logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
          r_sync[0] <= bus.source;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_srcS = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // prev registers reset high so a level already asserted at reset is not an event
  assign w_rise       = w_srcS & ~r_prevSrc;
  assign w_ackStart   = ~bus.dma_acknowledge_n & r_prevDack;
  assign w_modeChange = bus.mode_edge ^ r_prevMode;

  always_comb begin
    w_ack          = '0;
    w_ovfSet       = '0;
    w_requestNext  = '0;
    w_overflowNext = r_overflow;
    for (int n = 0; n < CHANNELS; n++) begin
      w_pendingNext[n] = '0;
      w_ack[n] = w_ackStart[n] & (r_pending[n] != '0);
      if (bus.channel_enable[n] && !w_modeChange[n]) begin
        if (bus.mode_edge[n]) begin
          if (w_rise[n] && !w_ack[n]) begin
            if (r_pending[n] == MaxPend) begin
              w_pendingNext[n] = MaxPend;
              w_ovfSet[n]      = 1'b1;
            end else begin
              w_pendingNext[n] = r_pending[n] + PEND_W'(1);
            end
          end else if (!w_rise[n] && w_ack[n]) begin
            w_pendingNext[n] = r_pending[n] - PEND_W'(1);
          end else begin
            w_pendingNext[n] = r_pending[n];
          end
          w_requestNext[n] = (w_pendingNext[n] != '0) & bus.dma_acknowledge_n[n];
        end else begin
          w_requestNext[n] = w_srcS[n];
        end
      end
      // a coincident saturation edge beats the clear pulse
      w_overflowNext[n] = w_ovfSet[n] | (r_overflow[n] & ~bus.overflow_clear[n]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prevSrc  <= '1;
      r_prevDack <= '1;
      r_prevMode <= bus.mode_edge;
      r_request  <= '0;
      r_overflow <= '0;
      for (int n = 0; n < CHANNELS; n++) r_pending[n] <= '0;
    end else begin
      r_prevSrc  <= w_srcS;
      r_prevDack <= bus.dma_acknowledge_n;
      r_prevMode <= bus.mode_edge;
      r_request  <= w_requestNext;
      r_overflow <= w_overflowNext;
      for (int n = 0; n < CHANNELS; n++) r_pending[n] <= w_pendingNext[n];
    end
  end

  always_comb begin
    w_pendFlat = '0;
    for (int n = 0; n < CHANNELS; n++) w_pendFlat[n*PEND_W +: PEND_W] = r_pending[n];
  end

  assign bus.dma_request   = r_request;
  assign bus.overflow      = r_overflow;
  assign bus.pending_count = w_pendFlat;

endmodule

// File: tb/tb_dma_request_gen.sv
// Directed bench for dma_request_gen: one unsynchronised instance for edge-mode
// scenarios and one with two synchroniser stages for level-mode latency.
module tb_dma_request_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nFail   = 0;

  always #5 clock = ~clock;

  dma_request_gen_if #(.CHANNELS(4), .PEND_W(2)) bus0 ();
  dma_request_gen_if #(.CHANNELS(4), .PEND_W(2)) bus2 ();

  dma_request_gen #(.CHANNELS(4), .PEND_W(2), .SYNC_STAGES(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  dma_request_gen #(.CHANNELS(4), .PEND_W(2), .SYNC_STAGES(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // Inputs change 1 time unit after each rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    nChecks++;
    if (bus0.dma_request !== 4'b0000) begin
      nFail++;
      $display("[TB] FAIL reset_request: got %b expected %b", bus0.dma_request, 4'b0000);
    end
    nChecks++;
    if (bus0.pending_count !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL reset_pending: got %h expected %h", bus0.pending_count, 8'h00);
    end
    nChecks++;
    if (bus0.overflow !== 4'b0000) begin
      nFail++;
      $display("[TB] FAIL reset_overflow: got %b expected %b", bus0.overflow, 4'b0000);
    end
    nChecks++;
    if (bus2.dma_request !== 4'b0000) begin
      nFail++;
      $display("[TB] FAIL reset_request_sync: got %b expected %b", bus2.dma_request, 4'b0000);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_edge_capture();
    bus0.source[0] = 1'b1;
    tick();
    nChecks++;
    if (bus0.dma_request[0] !== 1'b1 || bus0.pending_count[1:0] !== 2'd1) begin
      nFail++;
      $display("[TB] FAIL capture_rise: got req %b pend %0d expected req 1 pend 1",
               bus0.dma_request[0], bus0.pending_count[1:0]);
    end
    tick();
    tick();
    bus0.dma_acknowledge_n[0] = 1'b0;
    tick();
    nChecks++;
    if (bus0.dma_request[0] !== 1'b0 || bus0.pending_count[1:0] !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL capture_ack: got req %b pend %0d expected req 0 pend 0",
               bus0.dma_request[0], bus0.pending_count[1:0]);
    end
    bus0.dma_acknowledge_n[0] = 1'b1;
    tick();
    nChecks++;
    if (bus0.dma_request[0] !== 1'b0 || bus0.pending_count[1:0] !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL capture_release: got req %b pend %0d expected req 0 pend 0",
               bus0.dma_request[0], bus0.pending_count[1:0]);
    end
    bus0.source[0] = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    logic [1:0] expPend [4];
    logic [1:0] expAck  [3];
    expPend = '{2'd1, 2'd2, 2'd3, 2'd3};
    expAck  = '{2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 4; i++) begin
      bus0.source[0] = 1'b1;
      tick();
      nChecks++;
      if (bus0.pending_count[1:0] !== expPend[i] || bus0.overflow[0] !== (i == 3)) begin
        nFail++;
        $display("[TB] FAIL burst_rise%0d: got pend %0d ovf %b expected pend %0d ovf %b",
                 i, bus0.pending_count[1:0], bus0.overflow[0], expPend[i], (i == 3));
      end
      bus0.source[0] = 1'b0;
      tick();
    end
    bus0.overflow_clear[0] = 1'b1;
    tick();
    bus0.overflow_clear[0] = 1'b0;
    nChecks++;
    if (bus0.overflow[0] !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL burst_ovf_clear: got %b expected 0", bus0.overflow[0]);
    end
    for (int i = 0; i < 3; i++) begin
      bus0.dma_acknowledge_n[0] = 1'b0;
      tick();
      nChecks++;
      if (bus0.pending_count[1:0] !== expAck[i] || bus0.dma_request[0] !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL burst_ack%0d: got pend %0d req %b expected pend %0d req 0",
                 i, bus0.pending_count[1:0], bus0.dma_request[0], expAck[i]);
      end
      bus0.dma_acknowledge_n[0] = 1'b1;
      tick();
      nChecks++;
      if (bus0.dma_request[0] !== (expAck[i] != 2'd0)) begin
        nFail++;
        $display("[TB] FAIL burst_rearm%0d: got req %b expected %b",
                 i, bus0.dma_request[0], (expAck[i] != 2'd0));
      end
    end
  endtask

  task automatic test_simultaneous();
    bus0.source[0] = 1'b1;
    tick();
    bus0.source[0] = 1'b0;
    tick();
    bus0.source[0] = 1'b1;
    bus0.dma_acknowledge_n[0] = 1'b0;
    tick();
    nChecks++;
    if (bus0.pending_count[1:0] !== 2'd1 || bus0.dma_request[0] !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL simul_both: got pend %0d req %b expected pend 1 req 0",
               bus0.pending_count[1:0], bus0.dma_request[0]);
    end
    bus0.source[0] = 1'b0;
    bus0.dma_acknowledge_n[0] = 1'b1;
    tick();
    nChecks++;
    if (bus0.pending_count[1:0] !== 2'd1 || bus0.dma_request[0] !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL simul_release: got pend %0d req %b expected pend 1 req 1",
               bus0.pending_count[1:0], bus0.dma_request[0]);
    end
    bus0.dma_acknowledge_n[0] = 1'b0;
    tick();
    bus0.dma_acknowledge_n[0] = 1'b1;
    tick();
  endtask

  task automatic test_reset_enable();
    bus0.source[0] = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    nChecks++;
    if (bus0.dma_request[0] !== 1'b0 || bus0.pending_count[1:0] !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL enable_src_high_reset: got req %b pend %0d expected req 0 pend 0",
               bus0.dma_request[0], bus0.pending_count[1:0]);
    end
    bus0.source[0] = 1'b0;
    tick();
    bus0.source[0] = 1'b1;
    tick();
    bus0.source[0] = 1'b0;
    tick();
    bus0.source[0] = 1'b1;
    tick();
    nChecks++;
    if (bus0.pending_count[1:0] !== 2'd2) begin
      nFail++;
      $display("[TB] FAIL enable_build: got pend %0d expected 2", bus0.pending_count[1:0]);
    end
    bus0.channel_enable[0] = 1'b0;
    tick();
    nChecks++;
    if (bus0.dma_request[0] !== 1'b0 || bus0.pending_count[1:0] !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL enable_disable: got req %b pend %0d expected req 0 pend 0",
               bus0.dma_request[0], bus0.pending_count[1:0]);
    end
    bus0.channel_enable[0] = 1'b1;
    tick();
    tick();
    nChecks++;
    if (bus0.dma_request[0] !== 1'b0 || bus0.pending_count[1:0] !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL enable_reenable: got req %b pend %0d expected req 0 pend 0",
               bus0.dma_request[0], bus0.pending_count[1:0]);
    end
    bus0.source[0] = 1'b0;
    tick();
  endtask

  task automatic test_mode_change();
    bus0.source[1] = 1'b1;
    tick();
    nChecks++;
    if (bus0.pending_count[3:2] !== 2'd1 || bus0.dma_request[1] !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL mode_ch1_rise: got pend %0d req %b expected pend 1 req 1",
               bus0.pending_count[3:2], bus0.dma_request[1]);
    end
    bus0.mode_edge[1] = 1'b0;
    tick();
    nChecks++;
    if (bus0.pending_count[3:2] !== 2'd0 || bus0.dma_request[1] !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL mode_switch: got pend %0d req %b expected pend 0 req 0",
               bus0.pending_count[3:2], bus0.dma_request[1]);
    end
    tick();
    nChecks++;
    if (bus0.dma_request[1] !== 1'b1 || bus0.dma_request[0] !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL mode_level_follow: got req %b expected 0010", bus0.dma_request);
    end
    bus0.mode_edge[1] = 1'b1;
    bus0.source[1] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_level_sync();
    logic expReq;
    for (int i = 0; i < 10; i++) begin
      bus2.source[0] = (i < 5);
      bus2.dma_acknowledge_n[0] = !(i == 3 || i == 4);
      tick();
      expReq = (i >= 2 && i <= 6);
      nChecks++;
      if (bus2.dma_request[0] !== expReq || bus2.pending_count[1:0] !== 2'd0) begin
        nFail++;
        $display("[TB] FAIL level_cycle%0d: got req %b pend %0d expected req %b pend 0",
                 i, bus2.dma_request[0], bus2.pending_count[1:0], expReq);
      end
    end
    bus2.dma_acknowledge_n[0] = 1'b1;
  endtask

  task automatic test_underflow();
    bus0.source[2] = 1'b1;
    tick();
    bus0.source[2] = 1'b0;
    tick();
    bus0.source[2] = 1'b1;
    tick();
    bus0.source[2] = 1'b0;
    tick();
    bus0.source[2] = 1'b1;
    tick();
    bus0.source[2] = 1'b0;
    tick();
    bus0.source[2] = 1'b1;
    tick();
    bus0.source[2] = 1'b0;
    bus0.channel_enable[2] = 1'b0;
    tick();
    bus0.channel_enable[2] = 1'b1;
    tick();
    nChecks++;
    if (bus0.overflow[2] !== 1'b1 || bus0.pending_count[5:4] !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL underflow_setup: got ovf %b pend %0d expected ovf 1 pend 0",
               bus0.overflow[2], bus0.pending_count[5:4]);
    end
    bus0.dma_acknowledge_n[2] = 1'b0;
    tick();
    nChecks++;
    if (bus0.pending_count[5:4] !== 2'd0 || bus0.dma_request[2] !== 1'b0 || bus0.overflow[2] !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL underflow_ack: got pend %0d req %b ovf %b expected pend 0 req 0 ovf 1",
               bus0.pending_count[5:4], bus0.dma_request[2], bus0.overflow[2]);
    end
    bus0.dma_acknowledge_n[2] = 1'b1;
    tick();
    nChecks++;
    if (bus0.pending_count[5:4] !== 2'd0 || bus0.dma_request[2] !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL underflow_release: got pend %0d req %b expected pend 0 req 0",
               bus0.pending_count[5:4], bus0.dma_request[2]);
    end
  endtask

  initial begin
    bus0.source            = '0;
    bus0.mode_edge         = '1;
    bus0.channel_enable    = '1;
    bus0.dma_acknowledge_n = '1;
    bus0.overflow_clear    = '0;
    bus2.source            = '0;
    bus2.mode_edge         = 4'b1110;
    bus2.channel_enable    = '1;
    bus2.dma_acknowledge_n = '1;
    bus2.overflow_clear    = '0;
    #2;
    test_reset();
    test_edge_capture();
    test_burst();
    test_simultaneous();
    test_reset_enable();
    test_mode_change();
    test_level_sync();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
